// File: rtl/address_generation_stage_pkg.sv
// address_generation_stage_pkg: operand encodings, ModRM/SIB field positions and pipeline payloads.
// The s2_t payload gains a linear-address field when AGEN_LINEAR_EN is defined.
package address_generation_stage_pkg;
  localparam logic [2:0] SIZE_64 = 3'b011;
  typedef enum logic [1:0] {STK_NONE, STK_PUSH, STK_POP, STK_RSVD} stack_op_e;
  typedef enum logic [2:0] {SEG_ES, SEG_CS, SEG_SS, SEG_DS, SEG_FS, SEG_GS} seg_e;
  localparam int MOD_HI = 7, MOD_LO = 6, REG_HI = 5, REG_LO = 3, RM_HI = 2, RM_LO = 0;
  localparam int SS_HI = 7, SS_LO = 6, IDX_HI = 5, IDX_LO = 3, BASE_HI = 2, BASE_LO = 0;
  localparam logic [2:0] RM_SIB = 3'd4, REG_ESP = 3'd4, REG_EBP = 3'd5;
  typedef struct packed {
    logic        mem;
    logic [31:0] base_disp;
    logic [31:0] index_scaled;
    logic [2:0]  seg;
    logic [15:0] seg_val;
    logic [31:0] esp_next;
  } s1_t;
  typedef struct packed {
    logic        mem;
    logic [31:0] offset;
    logic [2:0]  seg;
    logic [15:0] seg_val;
    logic [31:0] esp_next;
`ifdef AGEN_LINEAR_EN
    logic [31:0] linear;
`endif
  } s2_t;
  function automatic logic [31:0] op_bytes(input logic [2:0] size);
    return size > SIZE_64 ? 32'd4 : 32'd1 << size[1:0];
  endfunction
endpackage

// File: rtl/address_generation_stage_if.sv
// address_generation_stage_if: upstream operand bus and downstream result bus of the AGU stage.
// a_linear exists only when AGEN_LINEAR_EN is defined.
interface address_generation_stage_if #(parameter int SB_W = 96);
  logic            flush;
  logic            r_valid, r_ready;
  logic [2:0]      r_size;
  logic [7:0]      r_modrm, r_sib;
  logic [31:0]     r_disp;
  logic [1:0]      r_stack_op;
  logic [2:0]      r_seg_override;
  logic            r_seg_override_valid;
  logic [31:0]     r_eax, r_ecx, r_edx, r_ebx, r_esp, r_ebp, r_esi, r_edi;
  logic [15:0]     r_es, r_cs, r_ss, r_ds, r_fs, r_gs;
  logic [SB_W-1:0] r_sb;
  logic            a_valid, a_ready, a_mem;
  logic [31:0]     a_offset, a_esp_next;
  logic [2:0]      a_seg;
  logic [15:0]     a_seg_val;
  logic [SB_W-1:0] a_sb;
`ifdef AGEN_LINEAR_EN
  logic [31:0]     a_linear;
`endif
  modport master (
    output flush, r_valid, r_size, r_modrm, r_sib, r_disp, r_stack_op, r_seg_override,
           r_seg_override_valid, r_eax, r_ecx, r_edx, r_ebx, r_esp, r_ebp, r_esi, r_edi,
           r_es, r_cs, r_ss, r_ds, r_fs, r_gs, r_sb, a_ready,
    input  r_ready, a_valid, a_mem, a_offset, a_esp_next, a_seg, a_seg_val, a_sb
`ifdef AGEN_LINEAR_EN
    , input a_linear
`endif
  );
  modport slave (
    input  flush, r_valid, r_size, r_modrm, r_sib, r_disp, r_stack_op, r_seg_override,
           r_seg_override_valid, r_eax, r_ecx, r_edx, r_ebx, r_esp, r_ebp, r_esi, r_edi,
           r_es, r_cs, r_ss, r_ds, r_fs, r_gs, r_sb, a_ready,
    output r_ready, a_valid, a_mem, a_offset, a_esp_next, a_seg, a_seg_val, a_sb
`ifdef AGEN_LINEAR_EN
    , output a_linear
`endif
  );
endinterface

// File: rtl/address_generation_stage_pipe_slice.sv
// agen_pipe_slice: one valid/ready register stage with synchronous flush and async reset.
module agen_pipe_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= flush ? 1'b0 : in_ready ? in_valid : out_valid;
      if (in_ready && in_valid && !flush) out_data <= in_data;
    end
  end
endmodule

// File: rtl/address_generation_stage.sv
// address_generation_stage: x86 effective-offset and segment selection, 2-cycle valid/ready pipeline.
// Define AGEN_LINEAR_EN to add the registered a_linear = {seg,4'b0} + offset output.
module address_generation_stage
  import address_generation_stage_pkg::*;
#(
  parameter int SB_W = 96
) (
  input logic clk,
  input logic reset,
  address_generation_stage_if.slave bus
);
  localparam int W1 = $bits(s1_t) + SB_W;
  localparam int W2 = $bits(s2_t) + SB_W;
  logic [7:0][31:0] gpr;
  logic [7:0][15:0] segs;
  logic [1:0] mod_f, ss_f;
  logic [2:0] rm_f, idx_f, base_reg;
  logic push, pop, stack, no_base, addr_none;
  logic [31:0] bytes, esp, disp_eff, index_val;
  s1_t s1_in, s1_q;
  s2_t s2_in, s2_q;
  logic [SB_W-1:0] sb1_q;
  logic [W1-1:0] s1_data;
  logic [W2-1:0] s2_data;
  logic s1_valid, s2_ready;
  logic unused_ok;
  assign gpr = {bus.r_edi, bus.r_esi, bus.r_ebp, bus.r_esp, bus.r_ebx, bus.r_edx, bus.r_ecx, bus.r_eax};
  assign segs = {16'h0, 16'h0, bus.r_gs, bus.r_fs, bus.r_ds, bus.r_ss, bus.r_cs, bus.r_es};
  assign unused_ok = &{1'b0, bus.r_modrm[REG_HI:REG_LO]};
  // SIB with mod=00 and base=101 means disp32 with no base register, mirroring the rm=101 case
  always_comb begin
    mod_f = bus.r_modrm[MOD_HI:MOD_LO];
    rm_f = bus.r_modrm[RM_HI:RM_LO];
    ss_f = bus.r_sib[SS_HI:SS_LO];
    idx_f = bus.r_sib[IDX_HI:IDX_LO];
    push = bus.r_stack_op == STK_PUSH;
    pop = bus.r_stack_op == STK_POP;
    stack = push || pop;
    addr_none = mod_f == 2'b11;
    base_reg = rm_f == RM_SIB ? bus.r_sib[BASE_HI:BASE_LO] : rm_f;
    no_base = mod_f == 2'b00 && base_reg == REG_EBP;
    disp_eff = mod_f == 2'b00 && !no_base ? 32'h0 : bus.r_disp;
    index_val = rm_f == RM_SIB && idx_f != REG_ESP ? gpr[idx_f] << ss_f : 32'h0;
    bytes = op_bytes(bus.r_size);
    esp = gpr[REG_ESP];
    s1_in.mem = stack || !addr_none;
    s1_in.base_disp = push ? esp - bytes : pop ? esp : addr_none ? 32'h0 :
                      (no_base ? 32'h0 : gpr[base_reg]) + disp_eff;
    s1_in.index_scaled = stack || addr_none ? 32'h0 : index_val;
    s1_in.seg = stack ? SEG_SS : bus.r_seg_override_valid ? bus.r_seg_override :
                !no_base && (base_reg == REG_ESP || base_reg == REG_EBP) ? SEG_SS : SEG_DS;
    s1_in.seg_val = segs[s1_in.seg];
    s1_in.esp_next = push ? esp - bytes : pop ? esp + bytes : esp;
  end
  agen_pipe_slice #(.WIDTH(W1)) u_s1 (
    .clk(clk), .reset(reset), .flush(bus.flush),
    .in_valid(bus.r_valid), .in_ready(bus.r_ready), .in_data({s1_in, bus.r_sb}),
    .out_valid(s1_valid), .out_ready(s2_ready), .out_data(s1_data)
  );
  assign {s1_q, sb1_q} = s1_data;
  always_comb begin
    s2_in.mem = s1_q.mem;
    s2_in.offset = s1_q.base_disp + s1_q.index_scaled;
    s2_in.seg = s1_q.seg;
    s2_in.seg_val = s1_q.seg_val;
    s2_in.esp_next = s1_q.esp_next;
`ifdef AGEN_LINEAR_EN
    s2_in.linear = {12'h0, s1_q.seg_val, 4'h0} + s2_in.offset;
`endif
  end
  agen_pipe_slice #(.WIDTH(W2)) u_s2 (
    .clk(clk), .reset(reset), .flush(bus.flush),
    .in_valid(s1_valid), .in_ready(s2_ready), .in_data({s2_in, sb1_q}),
    .out_valid(bus.a_valid), .out_ready(bus.a_ready), .out_data(s2_data)
  );
  assign {s2_q, bus.a_sb} = s2_data;
  assign bus.a_mem = s2_q.mem;
  assign bus.a_offset = s2_q.offset;
  assign bus.a_seg = s2_q.seg;
  assign bus.a_seg_val = s2_q.seg_val;
  assign bus.a_esp_next = s2_q.esp_next;
`ifdef AGEN_LINEAR_EN
  assign bus.a_linear = s2_q.linear;
`endif
endmodule
